// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and constants for the conv window controller
// Purpose: FSM state encoding, default image/kernel geometry and the
//          windows-per-frame helper used to size the optional window counter.
// Ports:   none (package)
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;
  localparam int DEF_K     = 5;

  // Number of valid K x K windows in a w x h frame (stride 1, no padding).
  function automatic int win_per_frame(input int w, input int h, input int k);
    return (h - k + 1) * (w - k + 1);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - column/row raster position counter
// Purpose: tracks the (col,row) position of a raster stream; advances on en,
//          wrapping col at W-1 and row at H-1.
// Ports:   clk, rst (sync, active high), clr (sync clear to 0,0), en (advance);
//          col/row (current position), row_wrap (en on last column),
//          frame_end (en on last column of last row). Strobes are combinational.
module raster_counter #(
  parameter int W     = 28,
  parameter int H     = 28,
  parameter int COL_W = 5,
  parameter int ROW_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             row_wrap,
  output logic             frame_end
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(H - 1);

  assign row_wrap  = en && (col == LAST_COL);
  assign frame_end = row_wrap && (row == LAST_ROW);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= (row == LAST_ROW) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// rtl/conv_window_ctrl.sv - line-buffer / K x K window sequencer for one frame
// Purpose: accepts a raster pixel stream after a start pulse, drives line
//          buffer write/rotate strobes and reports each complete K x K window
//          to a valid/ready consumer; pulses frame_done after the last window.
// Ports:   clk, rst (sync, active high), start;
//          pix_valid/pix_ready (pixel stream), lb_wr_en, lb_wr_col, lb_row_rot;
//          win_valid/win_ready, win_row, win_col, win_last_col (window);
//          frame_done, busy; win_cnt only when CONV_WIN_CNT_EN is defined.
// Option:  CONV_WIN_CNT_EN adds a per-frame consumed-window counter and a
//          check that it matches the expected count at frame_done.
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int K     = DEF_K,
  parameter int COL_W = $clog2(IMG_W),
  parameter int ROW_W = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic             lb_wr_en,
  output logic [COL_W-1:0] lb_wr_col,
  output logic             lb_row_rot,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [ROW_W-1:0] win_row,
  output logic [COL_W-1:0] win_col,
  output logic             win_last_col,
  output logic             frame_done,
  output logic             busy
`ifdef CONV_WIN_CNT_EN
  ,
  output logic [$clog2(win_per_frame(IMG_W, IMG_H, K) + 1)-1:0] win_cnt
`endif
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] K1_COL   = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] K1_ROW   = ROW_W'(K - 1);
  localparam logic [ROW_W-1:0] K2_ROW   = ROW_W'(K - 2);

  state_t           state;
  logic             accept;
  logic             frame_start;
  logic             win_set;
  logic [COL_W-1:0] in_col;
  logic [ROW_W-1:0] in_row;
  logic             row_wrap;
  logic             frame_end;

  // A held window blocks input so the window register is never overwritten
  // before it is consumed; when it is being consumed this cycle, input flows.
  assign pix_ready   = ((state == FILL) || (state == RUN)) && (!win_valid || win_ready);
  assign accept      = pix_valid && pix_ready;
  assign frame_start = (state == IDLE) && start;
  assign busy        = (state != IDLE);

  assign lb_wr_en    = accept;
  assign lb_wr_col   = in_col;
  assign lb_row_rot  = row_wrap;

  // The pixel that completes a window is the bottom-right one; the first K-1
  // columns of each row can never complete one, so windows never span rows.
  assign win_set = accept && (in_row >= K1_ROW) && (in_col >= K1_COL);

  raster_counter #(
    .W     (IMG_W),
    .H     (IMG_H),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_in_pos (
    .clk       (clk),
    .rst       (rst),
    .clr       (frame_start),
    .en        (accept),
    .col       (in_col),
    .row       (in_row),
    .row_wrap  (row_wrap),
    .frame_end (frame_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      win_valid    <= 1'b0;
      win_row      <= '0;
      win_col      <= '0;
      win_last_col <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // A new window takes priority over clearing the one being consumed.
      if (win_set) begin
        win_valid    <= 1'b1;
        win_row      <= in_row - K1_ROW;
        win_col      <= in_col - K1_COL;
        win_last_col <= (in_col == LAST_COL);
      end else if (win_valid && win_ready) begin
        win_valid <= 1'b0;
      end

      case (state)
        IDLE:  if (start) state <= FILL;
        FILL:  if (row_wrap && (in_row == K2_ROW)) state <= RUN;
        RUN:   if (frame_end) state <= DRAIN;
        // The frame's last pixel always completes a window, so win_valid is
        // set on entry and its consumption ends the frame.
        DRAIN: if (win_valid && win_ready) begin
          frame_done <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CONV_WIN_CNT_EN
  localparam int WPF = win_per_frame(IMG_W, IMG_H, K);

  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      win_cnt <= '0;
    end else if (win_valid && win_ready) begin
      win_cnt <= win_cnt + 1'b1;
    end
  end

  always @(posedge clk) begin
    if (!rst && frame_done) begin
      assert (win_cnt == ($bits(win_cnt))'(WPF));
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb/tb_conv_window_ctrl.sv - scoreboard bench for conv_window_ctrl
module tb_conv_window_ctrl;

  localparam int W  = 28;
  localparam int H  = 28;
  localparam int KK = 5;
  localparam int NW = (H - KK + 1) * (W - KK + 1);

  typedef struct {
    int r;
    int c;
    int last;
  } win_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, pix_valid, pix_ready, lb_wr_en, lb_row_rot;
  logic       win_valid, win_ready, win_last_col, frame_done, busy;
  logic [4:0] lb_wr_col, win_row, win_col;

  logic       s_start, s_pix_ready, s_lb_wr_en, s_lb_row_rot;
  logic       s_win_valid, s_win_ready, s_win_last_col, s_frame_done, s_busy;
  logic [2:0] s_lb_wr_col, s_win_row, s_win_col;

`ifdef CONV_WIN_CNT_EN
  logic [9:0] win_cnt;
  logic [2:0] s_win_cnt;
`endif

  conv_window_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .lb_wr_en(lb_wr_en), .lb_wr_col(lb_wr_col), .lb_row_rot(lb_row_rot),
    .win_valid(win_valid), .win_ready(win_ready), .win_row(win_row), .win_col(win_col),
    .win_last_col(win_last_col), .frame_done(frame_done), .busy(busy)
`ifdef CONV_WIN_CNT_EN
    , .win_cnt(win_cnt)
`endif
  );

  conv_window_ctrl #(.IMG_W(6), .IMG_H(6), .K(5)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .pix_valid(pix_valid), .pix_ready(s_pix_ready),
    .lb_wr_en(s_lb_wr_en), .lb_wr_col(s_lb_wr_col), .lb_row_rot(s_lb_row_rot),
    .win_valid(s_win_valid), .win_ready(s_win_ready), .win_row(s_win_row), .win_col(s_win_col),
    .win_last_col(s_win_last_col), .frame_done(s_frame_done), .busy(s_busy)
`ifdef CONV_WIN_CNT_EN
    , .win_cnt(s_win_cnt)
`endif
  );

  int   n_vec  = 0;
  int   n_miss = 0;
  win_t exp_q[$];
  win_t s_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor for the 28x28 instance: input-position model, latency check and
  // window scoreboard.
  int   m_col = 0, m_row = 0;
  int   acc_cnt = 0, rot_cnt = 0, pop_cnt = 0, done_cnt = 0;
  bit   pend = 0;
  int   pend_r = 0, pend_c = 0;
  win_t e_m;

  always @(negedge clk) begin
    if (rst) begin
      m_col = 0;
      m_row = 0;
      pend  = 0;
    end else begin
      if (pend) begin
        chk("win_latency_valid", win_valid, 1);
        chk("win_latency_row", win_row, pend_r);
        chk("win_latency_col", win_col, pend_c);
      end
      pend = 0;
      if (win_valid && win_ready) begin
        if (exp_q.size() == 0) begin
          chk("win_unexpected", 1, 0);
        end else begin
          e_m = exp_q.pop_front();
          chk("win_row", win_row, e_m.r);
          chk("win_col", win_col, e_m.c);
          chk("win_last_col", win_last_col, e_m.last);
          pop_cnt++;
        end
      end
      if (lb_row_rot) rot_cnt++;
      if (frame_done) done_cnt++;
      if (pix_valid && pix_ready) begin
        chk("lb_wr_en", lb_wr_en, 1);
        chk("lb_wr_col", lb_wr_col, m_col);
        chk("lb_row_rot", lb_row_rot, (m_col == W - 1));
        if (m_row >= KK - 1 && m_col >= KK - 1) begin
          pend   = 1;
          pend_r = m_row - (KK - 1);
          pend_c = m_col - (KK - 1);
        end
        acc_cnt++;
        if (m_col == W - 1) begin
          m_col = 0;
          m_row = (m_row == H - 1) ? 0 : m_row + 1;
        end else begin
          m_col++;
        end
      end else begin
        chk("lb_strobes_idle", {lb_wr_en, lb_row_rot}, 0);
      end
    end
  end

  // Monitor for the 6x6 instance.
  int   s_acc = 0;
  win_t e_s;

  always @(negedge clk) begin
    if (!rst) begin
      if (pix_valid && s_pix_ready) s_acc++;
      if (s_win_valid && s_win_ready) begin
        if (s_q.size() == 0) begin
          chk("s_win_unexpected", 1, 0);
        end else begin
          e_s = s_q.pop_front();
          chk("s_win_row", s_win_row, e_s.r);
          chk("s_win_col", s_win_col, e_s.c);
          chk("s_win_last_col", s_win_last_col, e_s.last);
        end
      end
    end
  end

  task automatic chk_reset_outputs();
    chk("reset_strobes", {pix_ready, lb_wr_en, lb_row_rot, win_valid, win_last_col, frame_done, busy}, 0);
    chk("reset_positions", {win_row, win_col, lb_wr_col}, 0);
  endtask

  // gap: percent of cycles without pix_valid; hold: stall win_ready at (0,23);
  // bad_start: pulse start during FILL and DRAIN; abort_row: reset when input reaches that row.
  task automatic run_frame(input int gap, input bit hold, input bit bad_start, input int abort_row);
    int a0, r0, p0, cyc;
    bit done, held;
    a0 = acc_cnt; r0 = rot_cnt; p0 = pop_cnt;
    cyc = 0; done = 0; held = 0;
    for (int r = 0; r <= H - KK; r++)
      for (int c = 0; c <= W - KK; c++)
        exp_q.push_back('{r, c, int'(c == W - KK)});
    start = 1;
    while (!done && cyc < 6000) begin
      pix_valid = ($urandom_range(99) >= gap);
      @(posedge clk); #1; cyc++;
      start = 0;
      if (frame_done) begin
        done = 1;
      end else begin
        if (bad_start && (cyc == 10 || acc_cnt - a0 == W * H)) start = 1;
        if (abort_row > 0 && m_row == abort_row) begin
          pix_valid = 0;
          rst = 1;
          @(posedge clk); #1;
          rst = 0;
          @(negedge clk);
          chk_reset_outputs();
          exp_q.delete();
          @(posedge clk); #1;
          return;
        end
        if (hold && !held && win_valid && win_row == 0 && win_col == W - KK) begin
          held = 1;
          win_ready = 0;
          repeat (3) begin
            @(negedge clk);
            chk("hold_pix_ready", pix_ready, 0);
            chk("hold_win_valid", win_valid, 1);
            chk("hold_win_pos", {win_row, win_col}, W - KK);
            chk("hold_win_last_col", win_last_col, 1);
            @(posedge clk); #1; cyc++;
          end
          win_ready = 1;
        end
      end
    end
    start = 0;
    pix_valid = 0;
    chk("frame_done_seen", done, 1);
    chk("pix_accepts", acc_cnt - a0, W * H);
    chk("row_rot_pulses", rot_cnt - r0, H);
    chk("windows_consumed", pop_cnt - p0, NW);
    chk("windows_left", exp_q.size(), 0);
    if (hold) chk("hold_happened", held, 1);
  endtask

  task automatic run_small_frame();
    int a0, cyc;
    bit done;
    a0 = s_acc; cyc = 0; done = 0;
    s_q.push_back('{0, 0, 0});
    s_q.push_back('{0, 1, 1});
    s_q.push_back('{1, 0, 0});
    s_q.push_back('{1, 1, 1});
    s_start = 1;
    pix_valid = 1;
    while (!done && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      s_start = 0;
      if (s_frame_done) done = 1;
    end
    pix_valid = 0;
    chk("s_frame_done_seen", done, 1);
    chk("s_pix_accepts", s_acc - a0, 36);
    chk("s_windows_left", s_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1; start = 0; pix_valid = 0; win_ready = 1;
    s_start = 0; s_win_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;

    run_frame(0, 0, 0, 0);
    run_frame(0, 1, 0, 0);
    run_frame(30, 0, 0, 0);
    run_frame(10, 0, 0, 10);
    run_frame(0, 0, 0, 0);
    run_frame(0, 0, 1, 0);
    run_frame(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    run_small_frame();
    repeat (2) @(posedge clk);
    #1;
    chk("frame_done_total", done_cnt, 6);
    chk("busy_after_all", {busy, s_busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
